// File: rtl/regs_arbiter_if.sv
// Requester-side and register-file-side signals of the round-robin register-file arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives requests and models the register file.
interface regs_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic                          rsp_err;
   logic [DATA_WIDTH-1:0]         rsp_rdata;

   logic                          rf_write_en;
   logic                          rf_read_en;
   logic [ADDR_WIDTH-1:0]         rf_addr;
   logic [DATA_WIDTH-1:0]         rf_write_data;
   logic [DATA_WIDTH-1:0]         rf_read_data;
   logic                          rf_data_ready;
   logic                          rf_write_done;
   logic                          rf_load_regs;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      input  rf_read_data, rf_data_ready, rf_write_done, rf_load_regs,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output rf_write_en, rf_read_en, rf_addr, rf_write_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      output rf_read_data, rf_data_ready, rf_write_done, rf_load_regs,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  rf_write_en, rf_read_en, rf_addr, rf_write_data
   );
endinterface

// File: rtl/regs_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single register-file port,
// one transaction at a time, with timeout and load_regs abort reported through rsp_err.
module regs_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 16,
   parameter int TIMEOUT    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   regs_arbiter_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
   localparam int ID_WIDTH   = $clog2(NUM_REQ);
   localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                  state_reg, state_next;
   logic [ID_WIDTH-1:0]     ptr_reg, ptr_next;
   logic [ID_WIDTH-1:0]     id_reg, id_next;
   logic                    we_reg, we_next;
   logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
   logic [NUM_REQ-1:0]      req_ready_reg, req_ready_next;
   logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
   logic                    rsp_err_reg, rsp_err_next;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
   logic                    rf_write_en_reg, rf_write_en_next;
   logic                    rf_read_en_reg, rf_read_en_next;
   logic [ADDR_WIDTH-1:0]   rf_addr_reg, rf_addr_next;
   logic [DATA_WIDTH-1:0]   rf_write_data_reg, rf_write_data_next;

   logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
   logic [NUM_REQ-1:0]      grant_oh;
   logic [NUM_REQ-1:0]      id_oh;
   logic                    grant_found;
   logic [ID_WIDTH-1:0]     grant_id;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign grant_oh[gi]  = (grant_id == ID_WIDTH'(gi));
      assign id_oh[gi]     = (id_reg == ID_WIDTH'(gi));
   end

   // First pending requester strictly after the last winner, wrapping around.
   always_comb begin
      int                  idx;
      logic [ID_WIDTH-1:0] cand;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(ptr_reg) + k) % NUM_REQ;
         cand = ID_WIDTH'(idx);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   always_comb begin
      state_next         = state_reg;
      ptr_next           = ptr_reg;
      id_next            = id_reg;
      we_next            = we_reg;
      cnt_next           = cnt_reg;
      req_ready_next     = '0;
      rsp_valid_next     = '0;
      rsp_err_next       = 1'b0;
      rsp_rdata_next     = rsp_rdata_reg;
      rf_write_en_next   = 1'b0;
      rf_read_en_next    = 1'b0;
      rf_addr_next       = rf_addr_reg;
      rf_write_data_next = rf_write_data_reg;

      case (state_reg)
         IDLE: begin
            if (grant_found && !bus.rf_load_regs) begin
               ptr_next           = grant_id;
               id_next            = grant_id;
               we_next            = bus.req_we[grant_id];
               rf_addr_next       = addr_arr[grant_id];
               rf_write_data_next = wdata_arr[grant_id];
               rf_write_en_next   = bus.req_we[grant_id];
               rf_read_en_next    = !bus.req_we[grant_id];
               req_ready_next     = grant_oh;
               state_next         = ISSUE;
            end
         end

         ISSUE: begin
            if (bus.rf_load_regs) begin
               rsp_valid_next = id_oh;
               rsp_err_next   = 1'b1;
               state_next     = IDLE;
            end else begin
               cnt_next   = '0;
               state_next = WAIT;
            end
         end

         WAIT: begin
            cnt_next = cnt_reg + 1'b1;
            // Abort outranks completion: the register file discards the access anyway.
            if (bus.rf_load_regs) begin
               rsp_valid_next = id_oh;
               rsp_err_next   = 1'b1;
               state_next     = IDLE;
            end else if (!we_reg && bus.rf_data_ready) begin
               rsp_valid_next = id_oh;
               rsp_rdata_next = bus.rf_read_data;
               state_next     = IDLE;
            end else if (we_reg && bus.rf_write_done) begin
               rsp_valid_next = id_oh;
               state_next     = IDLE;
            end else if (cnt_reg == CNT_WIDTH'(TIMEOUT - 1)) begin
               rsp_valid_next = id_oh;
               rsp_err_next   = 1'b1;
               state_next     = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         ptr_reg           <= ID_WIDTH'(NUM_REQ - 1);
         id_reg            <= '0;
         we_reg            <= 1'b0;
         cnt_reg           <= '0;
         req_ready_reg     <= '0;
         rsp_valid_reg     <= '0;
         rsp_err_reg       <= 1'b0;
         rsp_rdata_reg     <= '0;
         rf_write_en_reg   <= 1'b0;
         rf_read_en_reg    <= 1'b0;
         rf_addr_reg       <= '0;
         rf_write_data_reg <= '0;
      end else begin
         state_reg         <= state_next;
         ptr_reg           <= ptr_next;
         id_reg            <= id_next;
         we_reg            <= we_next;
         cnt_reg           <= cnt_next;
         req_ready_reg     <= req_ready_next;
         rsp_valid_reg     <= rsp_valid_next;
         rsp_err_reg       <= rsp_err_next;
         rsp_rdata_reg     <= rsp_rdata_next;
         rf_write_en_reg   <= rf_write_en_next;
         rf_read_en_reg    <= rf_read_en_next;
         rf_addr_reg       <= rf_addr_next;
         rf_write_data_reg <= rf_write_data_next;
      end
   end

   assign bus.req_ready     = req_ready_reg;
   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_err       = rsp_err_reg;
   assign bus.rsp_rdata     = rsp_rdata_reg;
   assign bus.rf_write_en   = rf_write_en_reg;
   assign bus.rf_read_en    = rf_read_en_reg;
   assign bus.rf_addr       = rf_addr_reg;
   assign bus.rf_write_data = rf_write_data_reg;
endmodule

// File: tb/tb_regs_arbiter.sv
// Directed bench for regs_arbiter: a behavioural register file with one read-only address,
// a vector table of single transactions, and hand-written arbitration, abort and reset sequences.
module tb_regs_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int DATA_DEPTH = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int TIMEOUT    = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regs_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   regs_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DATA_DEPTH(DATA_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Register file model: answers one cycle after the enable; address 9 is read-only.
   logic [7:0]  mem [16];
   logic [15:0] ro_mask = 16'h0200;
   logic        rf_stall;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.rf_data_ready <= 1'b0;
      bus.rf_write_done <= 1'b0;
      if (cyc == 0) begin
         for (int a = 0; a < 16; a++) mem[a] <= 8'(a * 17);
         mem[5]           <= 8'hA7;
         bus.rf_read_data <= 8'h00;
      end else if (!bus.rf_load_regs && !rf_stall) begin
         if (bus.rf_read_en) begin
            bus.rf_read_data  <= mem[bus.rf_addr];
            bus.rf_data_ready <= 1'b1;
         end
         if (bus.rf_write_en && !ro_mask[bus.rf_addr]) begin
            mem[bus.rf_addr]  <= bus.rf_write_data;
            bus.rf_write_done <= 1'b1;
         end
      end
   end

   typedef struct {
      int         id;
      bit         we;
      logic [3:0] addr;
      logic [7:0] wdata;
      bit         exp_err;
      logic [7:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   vec_t vecs [8];

   int         checks = 0;
   int         errors = 0;
   logic       seen_we, seen_re;
   logic [3:0] seen_addr;
   logic [7:0] seen_wdata;
   logic [3:0] seen_rsp;
   logic       seen_err;
   logic [7:0] seen_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int oh2id(input logic [3:0] v);
      oh2id = -1;
      for (int i = 3; i >= 0; i--) if (v[i]) oh2id = i;
   endfunction

   function automatic logic [3:0] onehot(input int i);
      onehot = 4'b0000;
      if (i >= 0 && i < 4) onehot[i] = 1'b1;
   endfunction

   task automatic set_fields(input int id, input bit we, input logic [3:0] addr, input logic [7:0] wdata);
      bus.req_we[id]          = we;
      bus.req_addr[id*4 +: 4]  = addr;
      bus.req_wdata[id*8 +: 8] = wdata;
   endtask

   task automatic wait_ready(output int id);
      id = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.req_ready != 4'b0000) begin
            id         = oh2id(bus.req_ready);
            seen_we    = bus.rf_write_en;
            seen_re    = bus.rf_read_en;
            seen_addr  = bus.rf_addr;
            seen_wdata = bus.rf_write_data;
            chk("ready_onehot", $countones(bus.req_ready), 1);
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no req_ready in 30 cycles, expected one");
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) chk("en_one_cycle", {30'd0, bus.rf_write_en, bus.rf_read_en}, 0);
         if (bus.rsp_valid != 4'b0000) begin
            lat        = n;
            seen_rsp   = bus.rsp_valid;
            seen_err   = bus.rsp_err;
            seen_rdata = bus.rsp_rdata;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid in 30 cycles, expected one");
   endtask

   // Issue from the requesters in mask; each granted requester optionally re-requests after its response.
   task automatic run_grants(input logic [3:0] mask, input int n, input logic [15:0] seq, input bit rereq);
      logic [3:0] pend;
      int         id;
      int         lat;
      pend          = mask;
      bus.req_valid = pend;
      for (int k = 0; k < n; k++) begin
         wait_ready(id);
         chk($sformatf("grant%0d", k), id, {30'd0, seq[2*k +: 2]});
         if (id >= 0) pend[id] = 1'b0;
         bus.req_valid = pend;
         wait_rsp(lat);
         chk($sformatf("grant%0d_rsp", k), seen_rsp, onehot(id));
         chk($sformatf("grant%0d_err", k), seen_err, 0);
         chk($sformatf("grant%0d_lat", k), lat, 2);
         $display("arb grant %0d: requester %0d, rsp_valid=%b err=%0d latency=%0d", k, id, seen_rsp, seen_err, lat);
         if (rereq && id >= 0) pend[id] = 1'b1;
         bus.req_valid = pend;
      end
      bus.req_valid = 4'b0000;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ready"}, bus.req_ready, 0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_err"}, bus.rsp_err, 0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_rf_en"}, {30'd0, bus.rf_write_en, bus.rf_read_en}, 0);
      chk({tag, "_rf_addr"}, bus.rf_addr, 0);
      chk({tag, "_rf_wdata"}, bus.rf_write_data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int id;
      int lat;

      vecs[0] = '{2, 1'b0, 4'd5,  8'h00, 1'b0, 8'hA7, 2};
      vecs[1] = '{0, 1'b1, 4'd3,  8'h5A, 1'b0, 8'hA7, 2};
      vecs[2] = '{1, 1'b0, 4'd3,  8'h00, 1'b0, 8'h5A, 2};
      vecs[3] = '{3, 1'b1, 4'd9,  8'h3C, 1'b1, 8'h5A, TIMEOUT + 1};
      vecs[4] = '{2, 1'b0, 4'd9,  8'h00, 1'b0, 8'h99, 2};
      vecs[5] = '{0, 1'b0, 4'd15, 8'h00, 1'b0, 8'hFF, 2};
      vecs[6] = '{3, 1'b1, 4'd0,  8'h01, 1'b0, 8'hFF, 2};
      vecs[7] = '{1, 1'b0, 4'd0,  8'h00, 1'b0, 8'h01, 2};

      rst_n            = 1'b0;
      rf_stall         = 1'b0;
      bus.rf_load_regs = 1'b0;
      bus.req_valid    = 4'b0000;
      bus.req_we       = 4'b0000;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");

      // All four pending at reset release: 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 4; i++) set_fields(i, 1'b0, 4'(i), 8'h00);
      bus.req_valid = 4'b1111;
      rst_n         = 1'b1;
      run_grants(4'b1111, 8, 16'b11_10_01_00_11_10_01_00, 1'b1);

      // Requesters 1 and 3 both re-requesting: 1,3,1,3.
      run_grants(4'b1010, 4, 16'b00_00_00_00_11_01_11_01, 1'b1);

      for (int v = 0; v < 8; v++) begin
         set_fields(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata);
         bus.req_valid = onehot(vecs[v].id);
         wait_ready(id);
         bus.req_valid = 4'b0000;
         chk($sformatf("v%0d_ready_id", v), id, vecs[v].id);
         chk($sformatf("v%0d_issue_we", v), seen_we, vecs[v].we);
         chk($sformatf("v%0d_issue_re", v), seen_re, !vecs[v].we);
         chk($sformatf("v%0d_issue_addr", v), seen_addr, vecs[v].addr);
         if (vecs[v].we) chk($sformatf("v%0d_issue_wdata", v), seen_wdata, vecs[v].wdata);
         wait_rsp(lat);
         chk($sformatf("v%0d_rsp_valid", v), seen_rsp, onehot(vecs[v].id));
         chk($sformatf("v%0d_rsp_err", v), seen_err, vecs[v].exp_err);
         chk($sformatf("v%0d_rsp_rdata", v), seen_rdata, vecs[v].exp_rdata);
         chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
         $display("txn %0d: req %0d %s addr %0d wdata 0x%02h -> rsp_valid=%b err=%0d rdata=0x%02h latency=%0d",
                  v, id, vecs[v].we ? "WR" : "RD", vecs[v].addr, vecs[v].wdata, seen_rsp, seen_err, seen_rdata, lat);
      end

      // load_regs during WAIT of a stalled read aborts it; nothing is granted while it stays high.
      rf_stall = 1'b1;
      set_fields(0, 1'b0, 4'd5, 8'h00);
      set_fields(1, 1'b0, 4'd2, 8'h00);
      bus.req_valid = 4'b0001;
      wait_ready(id);
      chk("abort_ready_id", id, 0);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("abort_wait_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      bus.rf_load_regs = 1'b1;
      bus.req_valid    = 4'b0010;
      @(negedge clk);
      chk("abort_rsp_valid", bus.rsp_valid, 4'b0001);
      chk("abort_rsp_err", bus.rsp_err, 1);
      chk("abort_rsp_rdata", bus.rsp_rdata, 8'h01);
      $display("txn abort: req 0 RD addr 5 -> rsp_valid=%b err=%0d rdata=0x%02h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("load_hold%0d_ready", i), bus.req_ready, 0);
         chk($sformatf("load_hold%0d_rf_en", i), {30'd0, bus.rf_write_en, bus.rf_read_en}, 0);
         @(negedge clk);
      end
      bus.rf_load_regs = 1'b0;
      rf_stall         = 1'b0;
      wait_ready(id);
      bus.req_valid = 4'b0000;
      chk("post_load_ready_id", id, 1);
      wait_rsp(lat);
      chk("post_load_rsp_valid", seen_rsp, 4'b0010);
      chk("post_load_rsp_err", seen_err, 0);
      chk("post_load_rsp_rdata", seen_rdata, 8'h22);
      $display("txn post-load: req 1 RD addr 2 -> rsp_valid=%b err=%0d rdata=0x%02h", seen_rsp, seen_err, seen_rdata);

      // Reset during WAIT clears outputs at once and produces no response for the lost request.
      rf_stall = 1'b1;
      set_fields(2, 1'b0, 4'd5, 8'h00);
      bus.req_valid = 4'b0100;
      wait_ready(id);
      chk("rst_ready_id", id, 2);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("async_rst");
      @(negedge clk);
      rst_n    = 1'b1;
      rf_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_rsp", i), bus.rsp_valid, 0);
      end
      set_fields(0, 1'b0, 4'd0, 8'h00);
      set_fields(2, 1'b0, 4'd2, 8'h00);
      run_grants(4'b0101, 2, 16'b00_00_00_00_00_00_10_00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
